// File: rtl/axi_aw_w_sync.sv
// axi_aw_w_sync: AW/W ordering gate for an AXI write path.
// Holds W until its AW is downstream and regenerates WLAST from AWLEN.
module axi_aw_w_sync #(
  parameter int AW_WIDTH        = 32,
  parameter int W_WIDTH         = 72,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = (MAX_OUTSTANDING > 1)
                    ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [AW_WIDTH-1:0] aw_data_i,
  input  logic [7:0]          aw_len_i,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  output logic [AW_WIDTH-1:0] aw_data_o,
  output logic [7:0]          aw_len_o,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [W_WIDTH-1:0]  w_data_i,
  input  logic                w_last_i,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [W_WIDTH-1:0]  w_data_o,
  output logic                w_last_o,
  output logic [CW-1:0]       outstanding_o,
  output logic                err_last_o,
  input  logic                clear_err_i
);

  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);

  logic [7:0]    len_q [MAX_OUTSTANDING];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    beat_cnt;
  logic          err;

  logic full;
  logic empty;
  logic push;
  logic beat;
  logic pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == MAX_CNT);
  assign empty = (count == '0);

  assign aw_valid_o = aw_valid_i & ~full;
  assign aw_ready_o = aw_ready_i & ~full;
  assign aw_data_o  = aw_data_i;
  assign aw_len_o   = aw_len_i;
  assign push       = aw_valid_o & aw_ready_i;

  assign w_valid_o = w_valid_i & ~empty;
  assign w_ready_o = w_ready_i & ~empty;
  assign w_data_o  = w_data_i;
  assign w_last_o  = ~empty & (beat_cnt == len_q[rd_ptr]);
  assign beat      = w_valid_o & w_ready_i;
  assign pop       = beat & w_last_o;

  assign outstanding_o = count;
  assign err_last_o    = err;

  // Burst-length storage, written at the tail on each forwarded AW
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) len_q[i] <= '0;
    end else if (push) begin
      len_q[wr_ptr] <= aw_len_i;
    end
  end

  // Queue pointers and occupancy; a push is visible to W next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Beat position within the head burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
    end
  end

  // Sticky WLAST mismatch; a new mismatch beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if (beat && (w_last_i != w_last_o)) begin
      err <= 1'b1;
    end else if (clear_err_i) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_aw_w_sync.sv
// tb_axi_aw_w_sync: directed corner cases, then random traffic
// checked by a queue scoreboard and a burst-level reference model.
module tb_axi_aw_w_sync;

  localparam int AW  = 32;
  localparam int WW  = 72;
  localparam int MO  = 4;
  localparam int CW  = $clog2(MO + 1);
  localparam int NB  = 1000;
  localparam int WDG = 60000;

  typedef logic [WW-1:0] v_t;
  typedef struct { logic [AW-1:0] d; logic [7:0] l; } awexp_t;
  typedef struct { logic [WW-1:0] d; logic l; } wexp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [AW-1:0] aw_data_i, aw_data_o;
  logic [7:0]    aw_len_i, aw_len_o;
  logic          w_valid_i, w_ready_o, w_last_i;
  logic          w_valid_o, w_ready_i, w_last_o;
  logic [WW-1:0] w_data_i, w_data_o;
  logic [CW-1:0] outstanding_o;
  logic          err_last_o, clear_err_i;

  always #5 clk = ~clk;

  axi_aw_w_sync #(
    .AW_WIDTH(AW), .W_WIDTH(WW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_data_i(aw_data_i), .aw_len_i(aw_len_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_data_o(aw_data_o), .aw_len_o(aw_len_o),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .w_data_i(w_data_i), .w_last_i(w_last_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_data_o(w_data_o), .w_last_o(w_last_o),
    .outstanding_o(outstanding_o),
    .err_last_o(err_last_o), .clear_err_i(clear_err_i)
  );

  int checks = 0;
  int errors = 0;

  awexp_t     exp_aw[$];
  wexp_t      exp_w[$];
  logic [7:0] lens[$];
  logic [7:0] fixed_len[6] = '{8'd0, 8'd255, 8'd1, 8'd2, 8'd0, 8'd3};

  logic mon_en = 1'b0;
  logic aw_done = 1'b0;
  logic w_done = 1'b0;
  logic timeout = 1'b0;
  int   m_out;
  logic m_err;
  logic m_push, m_pop, m_set;
  awexp_t ma;
  wexp_t  mw;

  task automatic chk(string name, v_t act, v_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aw_valid_i = 0; aw_ready_i = 0; aw_data_i = '0; aw_len_i = '0;
    w_valid_i = 0; w_ready_i = 0; w_data_i = '0; w_last_i = 0;
    clear_err_i = 0;
  endtask

  function automatic logic [7:0] pick_len();
    int r;
    r = $urandom_range(0, 99);
    if (r < 1) return 8'd255;
    if (r < 3) return 8'($urandom_range(4, 254));
    return 8'($urandom_range(0, 3));
  endfunction

  task automatic aw_drv();
    logic   hs;
    awexp_t e;
    for (int k = 0; k < NB; k++) begin
      e.l = (k < 6) ? fixed_len[k] : pick_len();
      e.d = $urandom;
      lens.push_back(e.l);
      exp_aw.push_back(e);
      while ($urandom_range(0, 3) == 0) tick();
      aw_data_i = e.d; aw_len_i = e.l; aw_valid_i = 1;
      do begin
        @(negedge clk);
        hs = aw_valid_o & aw_ready_i;
        tick();
      end while (!hs);
      aw_valid_i = 0; aw_data_i = $urandom; aw_len_i = 8'($urandom);
    end
    aw_done = 1;
  endtask

  task automatic w_drv();
    logic       hs;
    logic [7:0] l;
    wexp_t      e;
    for (int b = 0; b < NB; b++) begin
      while (lens.size() == 0) tick();
      l = lens.pop_front();
      for (int i = 0; i <= int'(l); i++) begin
        e.d = WW'({$urandom, $urandom, $urandom});
        e.l = (i == int'(l));
        exp_w.push_back(e);
        while ($urandom_range(0, 3) == 0) tick();
        w_data_i = e.d;
        w_last_i = e.l ^ ($urandom_range(0, 63) == 0);
        w_valid_i = 1;
        do begin
          @(negedge clk);
          hs = w_valid_o & w_ready_i;
          tick();
        end while (!hs);
        w_valid_i = 0;
      end
    end
    w_done = 1;
  endtask

  task automatic rdy_drv();
    forever begin
      aw_ready_i  = ($urandom_range(0, 3) != 0);
      w_ready_i   = ($urandom_range(0, 3) != 0);
      clear_err_i = ($urandom_range(0, 31) == 0);
      tick();
    end
  endtask

  // Scoreboard monitor: gating rules, payload order, WLAST, error flag
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("outstanding", v_t'(outstanding_o), v_t'(m_out));
      chk("err_last", v_t'(err_last_o), v_t'(m_err));
      chk("aw_valid_gate", v_t'(aw_valid_o),
          v_t'(aw_valid_i && (m_out < MO)));
      chk("aw_ready_gate", v_t'(aw_ready_o),
          v_t'(aw_ready_i && (m_out < MO)));
      chk("w_valid_gate", v_t'(w_valid_o),
          v_t'(w_valid_i && (m_out > 0)));
      chk("w_ready_gate", v_t'(w_ready_o),
          v_t'(w_ready_i && (m_out > 0)));
      m_push = 0; m_pop = 0; m_set = 0;
      if (w_valid_o && w_ready_i) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got beat %0h, want none", w_data_o);
        end else begin
          mw = exp_w.pop_front();
          chk("w_data", v_t'(w_data_o), v_t'(mw.d));
          chk("w_last", v_t'(w_last_o), v_t'(mw.l));
          m_set = (w_last_i != mw.l);
          m_pop = mw.l;
        end
      end
      if (aw_valid_o && aw_ready_i) begin
        if (exp_aw.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got aw %0h, want none", aw_data_o);
        end else begin
          ma = exp_aw.pop_front();
          chk("aw_data", v_t'(aw_data_o), v_t'(ma.d));
          chk("aw_len", v_t'(aw_len_o), v_t'(ma.l));
          m_push = 1;
        end
      end
      m_out = m_out + int'(m_push) - int'(m_pop);
      m_err = m_set ? 1'b1 : (clear_err_i ? 1'b0 : m_err);
    end
  end

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset state
    aw_valid_i = 1; w_valid_i = 1; w_ready_i = 1;
    #1;
    chk("rst_w_valid", v_t'(w_valid_o), v_t'(0));
    chk("rst_w_ready", v_t'(w_ready_o), v_t'(0));
    chk("rst_aw_valid", v_t'(aw_valid_o), v_t'(1));
    chk("rst_aw_ready", v_t'(aw_ready_o), v_t'(0));
    chk("rst_outst", v_t'(outstanding_o), v_t'(0));
    chk("rst_err", v_t'(err_last_o), v_t'(0));
    aw_valid_i = 0; aw_ready_i = 1;
    #1;
    chk("rst_aw_ready1", v_t'(aw_ready_o), v_t'(1));
    chk("rst_aw_valid0", v_t'(aw_valid_o), v_t'(0));

    // single len=3 burst, no bypass in the push cycle
    aw_valid_i = 1; aw_len_i = 8'd3;
    #1;
    chk("t1_no_bypass", v_t'(w_valid_o), v_t'(0));
    tick();
    aw_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      w_last_i = (i == 3);
      #1;
      chk("t1_w_valid", v_t'(w_valid_o), v_t'(1));
      chk("t1_w_last", v_t'(w_last_o), v_t'(i == 3));
      chk("t1_outst", v_t'(outstanding_o), v_t'(1));
      tick();
    end
    #1;
    chk("t1_outst_end", v_t'(outstanding_o), v_t'(0));
    chk("t1_w_valid_end", v_t'(w_valid_o), v_t'(0));

    // fill to MAX_OUTSTANDING, full blocks even with a pop
    w_ready_i = 0; w_last_i = 1;
    aw_len_i = 8'd0; aw_valid_i = 1;
    repeat (MO) tick();
    #1;
    chk("t2_outst_full", v_t'(outstanding_o), v_t'(MO));
    chk("t2_aw_valid_full", v_t'(aw_valid_o), v_t'(0));
    chk("t2_aw_ready_full", v_t'(aw_ready_o), v_t'(0));
    w_ready_i = 1;
    #1;
    chk("t2_pop_last", v_t'(w_last_o), v_t'(1));
    chk("t2_full_pop_block", v_t'(aw_valid_o), v_t'(0));
    tick();
    w_ready_i = 0;
    #1;
    chk("t2_aw_valid_after", v_t'(aw_valid_o), v_t'(1));
    chk("t2_outst_after", v_t'(outstanding_o), v_t'(MO - 1));
    tick();
    aw_valid_i = 0;
    #1;
    chk("t2_outst_refill", v_t'(outstanding_o), v_t'(MO));
    w_ready_i = 1;
    repeat (MO) tick();
    #1;
    chk("t2_outst_drain", v_t'(outstanding_o), v_t'(0));

    // early master WLAST sets the sticky error
    aw_len_i = 8'd3; aw_valid_i = 1;
    tick();
    aw_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      w_last_i = (i == 1);
      #1;
      if (i == 1) begin
        chk("t4_w_last_b2", v_t'(w_last_o), v_t'(0));
        chk("t4_err_before", v_t'(err_last_o), v_t'(0));
      end
      if (i == 2) chk("t4_err_set", v_t'(err_last_o), v_t'(1));
      if (i == 3) chk("t4_w_last_b4", v_t'(w_last_o), v_t'(1));
      tick();
    end
    w_valid_i = 0; clear_err_i = 1;
    #1;
    chk("t4_err_held", v_t'(err_last_o), v_t'(1));
    tick();
    clear_err_i = 0;
    #1;
    chk("t4_err_clear", v_t'(err_last_o), v_t'(0));
    chk("t4_outst", v_t'(outstanding_o), v_t'(0));

    // reset in the middle of a len=7 burst with two more queued
    w_valid_i = 1; w_ready_i = 0;
    aw_valid_i = 1; aw_len_i = 8'd7;
    tick();
    aw_len_i = 8'd0;
    tick();
    tick();
    aw_valid_i = 0; w_ready_i = 1; w_last_i = 1;
    tick();
    w_last_i = 0;
    tick();
    #1;
    chk("t5_err_pre", v_t'(err_last_o), v_t'(1));
    chk("t5_outst_pre", v_t'(outstanding_o), v_t'(3));
    rst_n = 0;
    #1;
    chk("t5_rst_outst", v_t'(outstanding_o), v_t'(0));
    chk("t5_rst_err", v_t'(err_last_o), v_t'(0));
    chk("t5_rst_w_valid", v_t'(w_valid_o), v_t'(0));
    tick();
    rst_n = 1;
    aw_valid_i = 1; aw_len_i = 8'd0; w_last_i = 1;
    tick();
    aw_valid_i = 0;
    #1;
    chk("t5_post_w_valid", v_t'(w_valid_o), v_t'(1));
    chk("t5_post_w_last", v_t'(w_last_o), v_t'(1));
    chk("t5_post_outst", v_t'(outstanding_o), v_t'(1));
    tick();
    #1;
    chk("t5_post_drain", v_t'(outstanding_o), v_t'(0));

    // random traffic under the scoreboard
    idle();
    tick();
    m_out = 0; m_err = 0; mon_en = 1;
    fork
      aw_drv();
      w_drv();
      rdy_drv();
    join_none
    fork
      begin
        while (!(aw_done && w_done &&
                 exp_aw.size() == 0 && exp_w.size() == 0)) tick();
      end
      begin
        repeat (WDG) @(posedge clk);
        timeout = 1;
      end
    join_any
    disable fork;
    idle();
    if (timeout) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d aw / %0d w pending, want 0",
               exp_aw.size(), exp_w.size());
    end
    repeat (3) tick();
    #1;
    chk("final_outst", v_t'(outstanding_o), v_t'(0));
    chk("final_aw_q", v_t'(exp_aw.size()), v_t'(0));
    chk("final_w_q", v_t'(exp_w.size()), v_t'(0));
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
